prod_table_mp: RTL and testbench



---
 rtl/prod_pkg.sv | 13 +
 rtl/prod_popcnt.sv | 13 +
 rtl/prod_table_mp.sv | 85 ++++++++
 tb/tb_prod_table_mp.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/prod_pkg.sv
// prod_pkg: shared defaults, entry type and tag-match helper for the producer table
package prod_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int TAG_W_DEF    = 5;
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
  } prod_entry_t;
  // Widths are passed zero-extended so any TAG_W up to 32 shares one helper
  function automatic logic tag_match(input logic valid, input logic [31:0] etag, input logic [31:0] tag);
    return !valid && etag == tag;
  endfunction
endpackage

// File: rtl/prod_popcnt.sv
// prod_popcnt: N-bit population count
module prod_popcnt #(
  parameter int N = 32,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int b = 0; b < N; b++) o_cnt = o_cnt + W'(i_bits[b]);
  end
endmodule

// File: rtl/prod_table_mp.sv
// prod_table_mp: register producer table with rename, NUM_RD lookups, NUM_WB wakeups and flush
// Optional PROD_TABLE_BYPASS_EN: a matching completion also raises rd_valid in the same cycle
module prod_table_mp
  import prod_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WB   = 2,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd_addr,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [NUM_WB*AW-1:0]     wb_addr,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic                     flush,
  output logic [CW-1:0]            pending_cnt,
  output logic                     all_ready
);
  logic [NUM_REGS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag [NUM_REGS];
  logic [NUM_REGS-1:0] w_wake;
  logic [NUM_REGS-1:0] w_byp;
  logic [NUM_REGS-1:0] w_nvalid;
  logic [TAG_W-1:0]    w_ntag [NUM_REGS];
  logic [CW-1:0]       w_cnt;

  always_comb begin
    w_wake   = '0;
    w_nvalid = '1;
    for (int j = 0; j < NUM_REGS; j++) w_ntag[j] = '0;
    for (int j = 1; j < NUM_REGS; j++) begin
      for (int k = 0; k < NUM_WB; k++)
        w_wake[j] = w_wake[j] | (wb_en[k] && wb_addr[k*AW +: AW] == AW'(j) &&
                    tag_match(r_valid[j], 32'(r_tag[j]), 32'(wb_tag[k*TAG_W +: TAG_W])));
      // Issue beats a same-cycle completion; flush beats both but leaves tags alone
      w_nvalid[j] = flush || (!(issue_en && issue_rd_addr == AW'(j)) && (r_valid[j] || w_wake[j]));
      w_ntag[j]   = (!flush && issue_en && issue_rd_addr == AW'(j)) ? issue_tag : r_tag[j];
    end
  end

`ifdef PROD_TABLE_BYPASS_EN
  assign w_byp = w_wake;
`else
  assign w_byp = '0;
`endif

  always_comb begin
    rd_valid = '0;
    rd_tag   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      rd_valid[i]                = (a == '0) || r_valid[a] || w_byp[a];
      rd_tag[i*TAG_W +: TAG_W]   = (a == '0) ? '0 : r_tag[a];
    end
  end

  prod_popcnt #(.N(NUM_REGS), .W(CW)) u_popcnt (
    .i_bits (~w_nvalid),
    .o_cnt  (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '1;
      for (int j = 0; j < NUM_REGS; j++) r_tag[j] <= '0;
      pending_cnt <= '0;
      all_ready   <= 1'b1;
    end else begin
      r_valid     <= w_nvalid;
      r_tag       <= w_ntag;
      pending_cnt <= w_cnt;
      all_ready   <= w_cnt == '0;
    end
  end
endmodule

// File: tb/tb_prod_table_mp.sv
// tb_prod_table_mp: directed checks of rename, wakeup, stale tags, flush, r0 and bypass timing
module tb_prod_table_mp;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       issue_en;
  logic [4:0] issue_rd_addr;
  logic [4:0] issue_tag;
  logic [9:0] rd_addr;
  logic [1:0] rd_valid;
  logic [9:0] rd_tag;
  logic [1:0] wb_en;
  logic [9:0] wb_addr;
  logic [9:0] wb_tag;
  logic       flush;
  logic [5:0] pending_cnt;
  logic       all_ready;
  int n_chk = 0;
  int n_pass = 0;
`ifdef PROD_TABLE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  prod_table_mp dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_rd_addr(issue_rd_addr),
    .issue_tag(issue_tag), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .flush(flush),
    .pending_cnt(pending_cnt), .all_ready(all_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    issue_en = 0; issue_rd_addr = 0; issue_tag = 0;
    rd_addr = 0; wb_en = 0; wb_addr = 0; wb_tag = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic iss(input int a, input int t);
    issue_en = 1; issue_rd_addr = 5'(a); issue_tag = 5'(t);
  endtask

  task automatic wb(input int k, input int a, input int t);
    wb_en[k] = 1; wb_addr[k*5 +: 5] = 5'(a); wb_tag[k*5 +: 5] = 5'(t);
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
    #1;
  endtask

  initial begin
    idle();
    #12;
    rd(5, 0);
    chk("rst_valid", 32'(rd_valid[0]), 1);
    chk("rst_cnt", 32'(pending_cnt), 0);
    chk("rst_all", 32'(all_ready), 1);
    rst_n = 1;
    tick();
    iss(5, 3);
    tick();
    rd(5, 0);
    chk("t1_valid", 32'(rd_valid[0]), 0);
    chk("t1_tag", 32'(rd_tag[4:0]), 3);
    chk("t1_cnt", 32'(pending_cnt), 1);
    #2 rst_n = 0;
    #1;
    chk("t1_arst_valid", 32'(rd_valid[0]), 1);
    chk("t1_arst_tag", 32'(rd_tag[4:0]), 0);
    chk("t1_arst_cnt", 32'(pending_cnt), 0);
    chk("t1_arst_all", 32'(all_ready), 1);
    rst_n = 1;
    tick();
    iss(7, 9);
    tick();
    rd(7, 0);
    chk("t2_valid", 32'(rd_valid[0]), 0);
    chk("t2_tag", 32'(rd_tag[4:0]), 9);
    chk("t2_cnt", 32'(pending_cnt), 1);
    chk("t2_all", 32'(all_ready), 0);
    wb(0, 7, 9);
    rd(0, 7);
    chk("t2_same_cycle", 32'(rd_valid[1]), 32'(BYP));
    chk("t2_port0_r0", 32'(rd_valid[0]), 1);
    tick();
    rd(7, 0);
    chk("t2_woke", 32'(rd_valid[0]), 1);
    chk("t2_cnt0", 32'(pending_cnt), 0);
    chk("t2_all1", 32'(all_ready), 1);
    iss(4, 2);
    tick();
    iss(4, 6);
    tick();
    wb(1, 4, 2);
    tick();
    rd(4, 0);
    chk("t3_stale_valid", 32'(rd_valid[0]), 0);
    chk("t3_stale_tag", 32'(rd_tag[4:0]), 6);
    chk("t3_stale_cnt", 32'(pending_cnt), 1);
    wb(0, 4, 6);
    tick();
    rd(4, 0);
    chk("t3_woke", 32'(rd_valid[0]), 1);
    chk("t3_cnt0", 32'(pending_cnt), 0);
    iss(3, 1);
    tick();
    iss(3, 8);
    wb(0, 3, 1);
    rd(3, 0);
    chk("t4_pre_tag", 32'(rd_tag[4:0]), 1);
    tick();
    rd(3, 0);
    chk("t4_valid", 32'(rd_valid[0]), 0);
    chk("t4_tag", 32'(rd_tag[4:0]), 8);
    chk("t4_cnt", 32'(pending_cnt), 1);
    wb(0, 3, 8);
    wb(1, 3, 8);
    tick();
    rd(0, 3);
    chk("t4_dual_wb", 32'(rd_valid[1]), 1);
    chk("t4_dual_cnt", 32'(pending_cnt), 0);
    iss(0, 4);
    tick();
    rd(0, 0);
    chk("t5_r0_valid", 32'(rd_valid[0]), 1);
    chk("t5_r0_tag", 32'(rd_tag[4:0]), 0);
    chk("t5_r0_cnt", 32'(pending_cnt), 0);
    for (int r = 1; r <= 10; r++) begin
      iss(r, r);
      tick();
    end
    chk("t5_cnt10", 32'(pending_cnt), 10);
    chk("t5_all0", 32'(all_ready), 0);
    rd(9, 2);
    chk("t5_port0_tag", 32'(rd_tag[4:0]), 9);
    chk("t5_port1_tag", 32'(rd_tag[9:5]), 2);
    flush = 1;
    iss(11, 20);
    wb(0, 2, 2);
    tick();
    chk("t5_flush_cnt", 32'(pending_cnt), 0);
    chk("t5_flush_all", 32'(all_ready), 1);
    rd(11, 2);
    chk("t5_r11_valid", 32'(rd_valid[0]), 1);
    chk("t5_r11_tag", 32'(rd_tag[4:0]), 0);
    chk("t5_r2_valid", 32'(rd_valid[1]), 1);
    chk("t5_r2_tag", 32'(rd_tag[9:5]), 2);
    iss(6, 12);
    tick();
    wb(1, 6, 12);
    rd(0, 6);
    chk("t6_bypass", 32'(rd_valid[1]), 32'(BYP));
    chk("t6_tag", 32'(rd_tag[9:5]), 12);
    chk("t6_cnt_pre", 32'(pending_cnt), 1);
    tick();
    rd(0, 6);
    chk("t6_next", 32'(rd_valid[1]), 1);
    chk("t6_cnt", 32'(pending_cnt), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
